// File: rtl/prince_inv_affine_pipe.sv
// Registered inverse A1 affine layer for the 3-share PRINCE S-box, one nibble map per share.
// Output register R0 plus skid register R1 give lossless back-pressure; both hold transformed data.
module prince_inv_affine_pipe #(
    parameter int          NIB     = 16,
    // Inverse of the forward nibble map a1(x) = rotl1(x) ^ 4'hC
    parameter logic [63:0] INV_LUT = 64'h9180_B3A2_D5C4_F7E6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4*NIB-1:0] x1,
    input  logic [4*NIB-1:0] x2,
    input  logic [4*NIB-1:0] x3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4*NIB-1:0] y1,
    output logic [4*NIB-1:0] y2,
    output logic [4*NIB-1:0] y3,
    input  logic             flush,
    output logic [1:0]       occupancy
);
    localparam int W = 4 * NIB;

    function automatic logic [W-1:0] inv_a1(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = '0;
        for (int i = 0; i < NIB; i++) begin
            y[4*i +: 4] = INV_LUT[4*int'(x[4*i +: 4]) +: 4];
        end
        return y;
    endfunction

    logic         r0_valid, r1_valid;
    logic [W-1:0] r0_y1, r0_y2, r0_y3;
    logic [W-1:0] r1_y1, r1_y2, r1_y3;
    logic [W-1:0] t1, t2, t3;
    logic         accept, pop;

    // Each share is mapped on its own; shares never meet.
    assign t1 = inv_a1(x1);
    assign t2 = inv_a1(x2);
    assign t3 = inv_a1(x3);

    assign in_ready  = !r1_valid;
    assign accept    = in_valid && in_ready;
    assign pop       = r0_valid && out_ready;
    assign out_valid = r0_valid;
    assign y1        = r0_y1;
    assign y2        = r0_y2;
    assign y3        = r0_y3;
    assign occupancy = {1'b0, r0_valid} + {1'b0, r1_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_valid <= 1'b0;
            r1_valid <= 1'b0;
            r0_y1    <= '0;
            r0_y2    <= '0;
            r0_y3    <= '0;
            r1_y1    <= '0;
            r1_y2    <= '0;
            r1_y3    <= '0;
        end else if (flush) begin
            r0_valid <= 1'b0;
            r1_valid <= 1'b0;
        end else if (!r0_valid) begin
            if (accept) begin
                r0_y1    <= t1;
                r0_y2    <= t2;
                r0_y3    <= t3;
                r0_valid <= 1'b1;
            end
        end else if (pop) begin
            // Skid entry is older than any new beat, so it moves forward first.
            if (r1_valid) begin
                r0_y1 <= r1_y1;
                r0_y2 <= r1_y2;
                r0_y3 <= r1_y3;
                if (accept) begin
                    r1_y1 <= t1;
                    r1_y2 <= t2;
                    r1_y3 <= t3;
                end else begin
                    r1_valid <= 1'b0;
                end
            end else if (accept) begin
                r0_y1 <= t1;
                r0_y2 <= t2;
                r0_y3 <= t3;
            end else begin
                r0_valid <= 1'b0;
            end
        end else if (accept) begin
            r1_y1    <= t1;
            r1_y2    <= t2;
            r1_y3    <= t3;
            r1_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_prince_inv_affine_pipe.sv
// Scoreboard bench for prince_inv_affine_pipe: expected beats queued on accept, compared on output.
module tb_prince_inv_affine_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [63:0] x1, x2, x3, y1, y2, y3;
    logic [1:0]  occupancy;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    prince_inv_affine_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .x3(x3), .out_valid(out_valid), .out_ready(out_ready),
        .y1(y1), .y2(y2), .y3(y3), .flush(flush), .occupancy(occupancy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Forward A1 nibble map; the inverse is found by search, not by table.
    function automatic logic [3:0] fwd_nib(input logic [3:0] x);
        return {x[2:0], x[3]} ^ 4'hC;
    endfunction

    function automatic logic [3:0] inv_nib(input logic [3:0] v);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (fwd_nib(4'(k)) == v) r = 4'(k);
        end
        return r;
    endfunction

    function automatic logic [63:0] fwd64(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = fwd_nib(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] inv64(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_nib(x[4*i +: 4]);
        return y;
    endfunction

    // One cycle: drive at negedge, check registered outputs, advance the model.
    task automatic step(input logic iv, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic ordy, input logic fl);
        int    occ;
        logic  acc, pp;
        beat_t e;
        @(negedge clk);
        in_valid  = iv;
        x1        = a;
        x2        = b;
        x3        = c;
        out_ready = ordy;
        flush     = fl;
        #1;
        occ = exp_q.size();
        check("occupancy", 64'(occupancy), 64'(occ));
        check("in_ready", 64'(in_ready), 64'(occ < 2));
        check("out_valid", 64'(out_valid), 64'(occ > 0));
        if (occ > 0 && out_valid) begin
            check("y1", y1, exp_q[0].a);
            check("y2", y2, exp_q[0].b);
            check("y3", y3, exp_q[0].c);
            check("unmasked", y1 ^ y2 ^ y3, exp_q[0].a ^ exp_q[0].b ^ exp_q[0].c);
        end
        acc = iv && (occ < 2);
        pp  = (occ > 0) && ordy;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pp) void'(exp_q.pop_front());
            if (acc) begin
                e.a = inv64(a);
                e.b = inv64(b);
                e.c = inv64(c);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 64'h0, 64'h0, 64'h0, ordy, 1'b0);
    endtask

    initial begin
        logic [63:0] o1, o2, o3;
        logic [63:0] ba[3];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        x1 = '0; x2 = '0; x3 = '0;
        #3;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst occupancy", 64'(occupancy), 64'd0);
        check("rst y", y1 | y2 | y3, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Round trip through the forward map, streaming with out_ready high.
        for (int n = 0; n < 10; n++) begin
            o1 = {$urandom, $urandom};
            o2 = {$urandom, $urandom};
            o3 = {$urandom, $urandom};
            step(1'b1, fwd64(o1), fwd64(o2), fwd64(o3), 1'b1, 1'b0);
            #1;
            check("rt y1", y1, o1);
            check("rt y2", y2, o2);
            check("rt y3", y3, o3);
            check("rt xor", y1 ^ y2 ^ y3, o1 ^ o2 ^ o3);
        end
        idle(1'b1);
        idle(1'b1);

        // Table sweep.
        step(1'b1, 64'h0123456789ABCDEF, 64'h0, 64'h0, 1'b1, 1'b0);
        #1;
        for (int i = 0; i < 16; i++) begin
            check("sweep nib", 64'(y1[4*i +: 4]), 64'(inv_nib(4'(15 - i))));
        end
        check("sweep y2", y2, {16{inv_nib(4'h0)}});
        idle(1'b1);

        // Back-pressure: A,B,C with out_ready low, then release.
        for (int k = 0; k < 3; k++) ba[k] = {$urandom, $urandom};
        step(1'b1, ba[0], ~ba[0], ba[0] ^ 64'h5A5A, 1'b0, 1'b0);
        step(1'b1, ba[1], ~ba[1], ba[1] ^ 64'h5A5A, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, ba[2], ~ba[2], ba[2] ^ 64'h5A5A, 1'b0, 1'b0);
        step(1'b1, ba[2], ~ba[2], ba[2] ^ 64'h5A5A, 1'b1, 1'b0);
        step(1'b1, ba[2], ~ba[2], ba[2] ^ 64'h5A5A, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) idle(1'b1);

        // Pop + accept at occupancy 1 and at occupancy 2.
        step(1'b1, 64'h1111, 64'h2222, 64'h3333, 1'b0, 1'b0);
        step(1'b1, 64'h4444, 64'h5555, 64'h6666, 1'b1, 1'b0);
        step(1'b1, 64'h7777, 64'h8888, 64'h9999, 1'b0, 1'b0);
        step(1'b1, 64'hAAAA, 64'hBBBB, 64'hCCCC, 1'b1, 1'b0);
        step(1'b1, 64'hAAAA, 64'hBBBB, 64'hCCCC, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) idle(1'b1);

        // Flush at occupancy 2 with a beat offered in the same cycle.
        step(1'b1, 64'hDEAD, 64'hBEEF, 64'hCAFE, 1'b0, 1'b0);
        step(1'b1, 64'hF00D, 64'h1234, 64'h5678, 1'b0, 1'b0);
        step(1'b1, 64'h9ABC, 64'hDEF0, 64'h1357, 1'b0, 1'b1);
        idle(1'b1);

        // Asynchronous reset mid-cycle at occupancy 2.
        step(1'b1, 64'h0F0F, 64'hF0F0, 64'h3C3C, 1'b0, 1'b0);
        step(1'b1, 64'hC3C3, 64'h6969, 64'h9696, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst out_valid", 64'(out_valid), 64'd0);
        check("arst y", y1 | y2 | y3, 64'd0);
        check("arst occupancy", 64'(occupancy), 64'd0);
        check("arst in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 64'h0123, 64'h4567, 64'h89AB, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
